mdu_seq: RTL and testbench

- Multi-cycle sequencer for the RV32IM M-extension operations. It replaces single-cycle multiply/divide in the integer ALU path.
- It accepts one operation from the EX stage and runs a radix-2 iterative shift-add multiply or restoring divide over 32 cycles.
- It stalls the pipeline while busy and presents a registered result with a one-cycle DONE pulse.
- It sits beside alu_int in EX. EX-stage control selects RESULT from this block when DONE is high.

---
 rtl/mdu_pkg.sv | 18 +
 rtl/mdu_datapath.sv | 34 +++
 rtl/mdu_seq.sv | 109 ++++++++++
 tb/tb_mdu_seq.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared constants, op codes and state encoding for the M-extension sequencer.
package mdu_pkg;
  localparam int XLEN = 32;
  localparam int ITER = 32;
  localparam int CW = $clog2(ITER);
  localparam logic [4:0] OP_MUL    = 5'd8;
  localparam logic [4:0] OP_MULH   = 5'd9;
  localparam logic [4:0] OP_MULHSU = 5'd10;
  localparam logic [4:0] OP_MULHU  = 5'd11;
  localparam logic [4:0] OP_DIV    = 5'd12;
  localparam logic [4:0] OP_DIVU   = 5'd13;
  localparam logic [4:0] OP_REM    = 5'd14;
  localparam logic [4:0] OP_REMU   = 5'd15;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;
  function automatic logic is_m(input logic [4:0] op);
    return op[4:3] == 2'b01;
  endfunction
endpackage

// File: rtl/mdu_datapath.sv
// mdu_datapath: 64-bit product / remainder:quotient register with one shift-add or restoring-divide step per cycle.
module mdu_datapath
  import mdu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic              div,
  input  logic [XLEN-1:0]   a_in,
  input  logic [XLEN-1:0]   b_in,
  output logic [2*XLEN-1:0] p
);
  logic [XLEN-1:0] b;
  logic [XLEN:0]   sum;
  logic [XLEN-1:0] dif;
  logic            lt;
  assign sum = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, b} : {(XLEN+1){1'b0}});
  // the shifted partial remainder needs XLEN+1 bits when the divisor exceeds 2^(XLEN-1)
  assign lt  = p[2*XLEN-1:XLEN-1] < {1'b0, b};
  assign dif = p[2*XLEN-2:XLEN-1] - b;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b <= '0;
      p <= '0;
    end else if (load) begin
      b <= div ? b_in : a_in;
      p <= {{XLEN{1'b0}}, div ? a_in : b_in};
    end else if (step) begin
      p <= div ? (lt ? {p[2*XLEN-2:0], 1'b0} : {dif, p[XLEN-2:0], 1'b1})
               : {sum, p[XLEN-1:1]};
    end
  end
endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle RV32M multiply/divide sequencer with pipeline stall and one-cycle done pulse.
module mdu_seq
  import mdu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [4:0]      alu_op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic            stall,
  output logic            done
);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
  state_t          state;
  logic [4:0]      op_q;
  logic [CW-1:0]   cnt;
  logic            neg_q, neg_r;
  logic            s1, s2, n1, n2, is_div, is_rem, div0, ovf, go, load, step;
  logic [XLEN-1:0] m1, m2, spec_res, quo, rem, fixed;
  logic [2*XLEN-1:0] p, prod;
  assign s1 = alu_op == OP_MULH || alu_op == OP_MULHSU || alu_op == OP_DIV || alu_op == OP_REM;
  assign s2 = alu_op == OP_MULH || alu_op == OP_DIV || alu_op == OP_REM;
  assign n1 = s1 & op1[XLEN-1];
  assign n2 = s2 & op2[XLEN-1];
  assign m1 = n1 ? -op1 : op1;
  assign m2 = n2 ? -op2 : op2;
  assign is_div = alu_op[4:2] == 3'b011;
  assign is_rem = is_div & alu_op[1];
  assign div0 = is_div && op2 == '0;
  assign ovf = (alu_op == OP_DIV || alu_op == OP_REM) && op1 == MIN_INT && op2 == '1;
  assign spec_res = div0 ? (is_rem ? op1 : '1) : (is_rem ? '0 : MIN_INT);
  assign go = state == IDLE && start && !flush && is_m(alu_op);
  assign load = go && !div0 && !ovf;
  assign step = state == CALC && !flush;
  assign stall = busy | (start & state == IDLE & is_m(alu_op));
  assign prod = neg_q ? -p : p;
  assign quo = neg_q ? -p[XLEN-1:0] : p[XLEN-1:0];
  assign rem = neg_r ? -p[2*XLEN-1:XLEN] : p[2*XLEN-1:XLEN];
  assign fixed = op_q == OP_MUL ? prod[XLEN-1:0]
               : op_q[2] ? (op_q[1] ? rem : quo) : prod[2*XLEN-1:XLEN];
  mdu_datapath u_dp (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .step (step),
    .div  (state == IDLE ? is_div : op_q[2]),
    .a_in (m1),
    .b_in (m2),
    .p    (p)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (go) begin
            op_q  <= alu_op;
            neg_q <= n1 ^ n2;
            neg_r <= n1;
            cnt   <= '0;
            if (load) begin
              state <= CALC;
              busy  <= 1'b1;
            end else begin
              state  <= DONE;
              done   <= 1'b1;
              result <= spec_res;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= FIX;
          end
        end
        FIX: begin
          state <= flush ? IDLE : DONE;
          busy  <= 1'b0;
          if (!flush) begin
            result <= fixed;
            done   <= 1'b1;
          end
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed vectors with a result queue checked by an independent done monitor.
module tb_mdu_seq;
  import mdu_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0;
  logic [4:0]  alu_op = '0;
  logic [31:0] op1 = '0, op2 = '0;
  logic [31:0] result;
  logic        busy, stall, done;
  int          total = 0, bad = 0, ndone = 0, d0;
  logic [31:0] exp_q[$];
  logic [31:0] e_mon;

  mdu_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .flush (flush),
    .alu_op(alu_op),
    .op1   (op1),
    .op2   (op2),
    .result(result),
    .busy  (busy),
    .stall (stall),
    .done  (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) begin
      ndone++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done result=%h required=no done", result);
      end else begin
        e_mon = exp_q.pop_front();
        if (result !== e_mon) begin
          bad++;
          $display("FAIL result got=%h required=%h", result, e_mon);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int lat);
    int n, st;
    @(posedge clk); #1;
    exp_q.push_back(exp);
    alu_op = op; op1 = a; op2 = b; start = 1'b1;
    #1;
    st = stall;
    n = 0;
    @(posedge clk); #1;
    start = 1'b0; alu_op = '0;
    while (!done && n < 100) begin
      st += stall;
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, lat);
    chk("stall_cycles", st, lat + 1);
    @(posedge clk); #1;
  endtask

  task automatic idle_wait_no_done(input string name);
    d0 = ndone;
    repeat (40) @(posedge clk);
    #1;
    chk(name, ndone - d0, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_result", result, 32'h0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_stall", stall, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run(OP_MUL,    32'd7,        32'd6,        32'h0000002A, 33);
    run(OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
    run(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run(OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
    run(OP_MUL,    32'h12345678, 32'h10,       32'h23456780, 33);
    run(OP_DIVU,   32'd100,      32'd7,        32'd14,       33);
    run(OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run(OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run(OP_REMU,   32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 33);
    run(OP_DIV,    32'd55,       32'd0,        32'hFFFFFFFF, 0);
    run(OP_DIVU,   32'd55,       32'd0,        32'hFFFFFFFF, 0);
    run(OP_REM,    32'd5,        32'd0,        32'd5,        0);
    run(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
    run(OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0);
    run(OP_REMU,   32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 33);

    // flush mid-calculation: no done, result retained
    @(posedge clk); #1;
    alu_op = OP_DIVU; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_stall", stall, 0);
    idle_wait_no_done("flush_no_done");
    chk("flush_result_kept", result, 32'h7FFFFFFE);
    run(OP_REMU, 32'd100, 32'd7, 32'd2, 33);

    // flush in idle drops a simultaneous request
    @(posedge clk); #1;
    alu_op = OP_DIV; op1 = 32'd10; op2 = 32'd2; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("idle_flush_busy", busy, 0);
    idle_wait_no_done("idle_flush_no_done");

    // non-M op is ignored
    @(posedge clk); #1;
    alu_op = 5'd0; op1 = 32'd3; op2 = 32'd4; start = 1'b1;
    #1 chk("nonm_stall", stall, 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("nonm_busy", busy, 0);
    idle_wait_no_done("nonm_no_done");

    // asynchronous reset mid-multiply
    @(posedge clk); #1;
    alu_op = OP_MUL; op1 = 32'd3; op2 = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1 chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_wait_no_done("rst_no_done");
    run(OP_MUL, 32'd3, 32'd5, 32'h0000000F, 33);

    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
